alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Registered issuing front-end for the datapath ALU: accepts one LEGv8 operation per handshake, decodes the 11-bit opcode into the 4-bit ALU control code, and drives the ALU operand buses and control. It then captures the ALU result and zero flag and returns them on a valid/ready response port. It sits between the instruction/control path and the combinational ALU, which acts as a responder to this block.

## Interface
- DATA_W, 64, operand/result width; matches ALU bus width
- CNT_W, 16, width of completed-operation counter
- CLK  input  1  sole clock, rising edge
- resetl  input  1  synchronous active-low reset
- op_valid  input  1  request valid
- op_ready  output  1  request accepted when op_valid && op_ready at CLK edge
- Opcode  input  11  LEGv8 opcode
- OperandA  input  DATA_W  first operand
- OperandB  input  DATA_W  second operand
- AluCtrl  output  4  to ALU control input
- BusA  output  DATA_W  to ALU operand A
- BusB  output  DATA_W  to ALU operand B
- BusW  input  DATA_W  from ALU result
- Zero  input  1  from ALU zero flag
- res_valid  output  1  response valid
- res_ready  input  1  response consumed when res_valid && res_ready at CLK edge
- Result  output  DATA_W  captured BusW
- ResZero  output  1  captured Zero
- Illegal  output  1  opcode not decodable; Result=0, ResZero=0
- op_count  output  CNT_W  number of completed responses, wraps modulo 2^CNT_W

## Operation
- Decode (exact match unless noted): ADD 10001011000→0010; SUB 11001011000→0110; AND 10001010000→0000; ORR 10101010000→0001; LDUR 11111000010→0010; STUR 11111000000→0010; CBZ 10110100xxx (low 3 bits don't-care)→0111 (PassB). Any other opcode is illegal.
- States: IDLE, EXEC, RESP.
- IDLE: op_ready=1. On accept of a legal op: register AluCtrl, BusA←OperandA, BusB←OperandB; go to EXEC. On accept of an illegal op: leave AluCtrl/BusA/BusB unchanged; set Illegal=1, Result=0, ResZero=0; go to RESP.
- EXEC: op_ready=0. ALU is combinational. At the end of EXEC, capture Result←BusW, ResZero←Zero, Illegal←0; go to RESP.
- RESP: res_valid=1, op_ready=0. Result, ResZero, and Illegal are held stable until the handshake. On res_ready: op_count increments (wrapping), go to IDLE.
- AluCtrl, BusA, and BusB hold their last issued values outside EXEC. They change only on a legal accept.
- No arithmetic in this block; width rules are owned by the ALU.

## Timing
- Reset (resetl low at CLK edge): state=IDLE; AluCtrl=0000, BusA=0, BusB=0, Result=0, ResZero=0, Illegal=0, res_valid=0, op_count=0. op_ready is forced 0 while resetl is low.
- Legal op accepted at edge t: AluCtrl/BusA/BusB are valid after t. Result is captured at t+1. res_valid is high after t+1. Latency is 2 cycles.
- Illegal op accepted at edge t: res_valid is high after t. Latency is 1 cycle.
- Minimum issue interval is 3 cycles (legal) or 2 cycles (illegal), because op_ready is high only in IDLE. There is no request/response overlap.
- Response handshake at edge t: res_valid is low and op_ready is high after t.
- Reset asserted in EXEC or RESP aborts the operation: no response, no count increment, all outputs take reset values at that edge.
- op_valid deasserted in IDLE: no state change.
- Inputs Opcode and OperandA/B are sampled only at the accept edge.

## Structure
- Shared package alu_pkg holds:
  - ALU control constants: AND 0000, OR 0001, ADD 0010, SUB 0110, PassB 0111.
  - LEGv8 opcode constants, including the CBZ 8-bit prefix.
  - The state encoding.
- Sub-module alu_ctrl_decode: purely combinational, Opcode→{AluCtrl, illegal}. It is reused by the single-cycle control unit.
- Top level contains the FSM, operand/control registers, result capture, and counter.

## Test plan
- ADD opcode, A=5, B=7 → AluCtrl=0010 after accept; 2 cycles later res_valid=1, Result=12, ResZero=0, Illegal=0; op_count=1 after handshake.
- SUB opcode, A=9, B=9 → AluCtrl=0110, Result=0, ResZero=1.
- CBZ opcode 10110100101, A=0xFF, B=0 → AluCtrl=0111, Result=0, ResZero=1. Repeat with B=3 → Result=3, ResZero=0.
- Opcode 00000000000 → res_valid 1 cycle after accept, Illegal=1, Result=0; AluCtrl/BusA/BusB unchanged from the previous op.
- ORR with res_ready held low 5 cycles → res_valid and Result stable all 5 cycles, op_ready=0; accepts only after handshake.
- resetl low during EXEC → next cycle all outputs at reset values, op_count=0, no response; following ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, LEGv8 opcodes and sequencer state encoding
package alu_pkg;
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_PASSB = 4'b0111;
  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0] OP_CBZ_PREFIX = 8'b10110100;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational LEGv8 opcode to ALU control decode with illegal flag
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [10:0] Opcode,
  output logic [3:0]  AluCtrl,
  output logic        illegal
);
  logic is_cbz;
  assign is_cbz = Opcode[10:3] == OP_CBZ_PREFIX;
  always_comb begin
    AluCtrl = (Opcode == OP_ADD || Opcode == OP_LDUR || Opcode == OP_STUR) ? CTRL_ADD :
              (Opcode == OP_SUB) ? CTRL_SUB :
              (Opcode == OP_ORR) ? CTRL_OR :
              is_cbz ? CTRL_PASSB : CTRL_AND;
    illegal = !(Opcode == OP_ADD || Opcode == OP_SUB || Opcode == OP_AND || Opcode == OP_ORR ||
                Opcode == OP_LDUR || Opcode == OP_STUR || is_cbz);
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: handshaked issue front-end driving the ALU and returning its result
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [10:0]       Opcode,
  input  logic [DATA_W-1:0] OperandA,
  input  logic [DATA_W-1:0] OperandB,
  output logic [3:0]        AluCtrl,
  output logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] BusB,
  input  logic [DATA_W-1:0] BusW,
  input  logic              Zero,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] Result,
  output logic              ResZero,
  output logic              Illegal,
  output logic [CNT_W-1:0]  op_count
);
  state_t state, next_state;
  logic [3:0] dec_ctrl;
  logic dec_illegal, accept;
  alu_ctrl_decode u_dec (.Opcode(Opcode), .AluCtrl(dec_ctrl), .illegal(dec_illegal));
  assign op_ready = resetl && state == IDLE;
  assign res_valid = state == RESP;
  assign accept = op_valid && op_ready;
  always_comb begin
    next_state = state == IDLE ? (accept ? (dec_illegal ? RESP : EXEC) : IDLE) :
                 state == EXEC ? RESP :
                 res_ready ? IDLE : RESP;
  end
  always_ff @(posedge CLK) begin
    if (!resetl) state <= IDLE;
    else state <= next_state;
  end
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      AluCtrl <= CTRL_AND;
      BusA <= '0;
      BusB <= '0;
      Result <= '0;
      ResZero <= 1'b0;
      Illegal <= 1'b0;
      op_count <= '0;
    end else begin
      if (accept && !dec_illegal) begin
        AluCtrl <= dec_ctrl;
        BusA <= OperandA;
        BusB <= OperandB;
      end
      if (accept && dec_illegal) begin
        Illegal <= 1'b1;
        Result <= '0;
        ResZero <= 1'b0;
      end
      if (state == EXEC) begin
        Result <= BusW;
        ResZero <= Zero;
        Illegal <= 1'b0;
      end
      if (res_valid && res_ready) op_count <= op_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized self-checking bench with an ALU responder and mnemonic-level model
module tb_alu_op_sequencer;
  logic CLK = 1'b0;
  logic resetl = 1'b0;
  logic op_valid = 1'b0;
  logic res_ready = 1'b0;
  logic [10:0] Opcode = '0;
  logic [63:0] OperandA = '0, OperandB = '0;
  logic op_ready, res_valid, ResZero, Illegal, Zero;
  logic [3:0] AluCtrl;
  logic [63:0] BusA, BusB, BusW, Result;
  logic [15:0] op_count;
  int n_checks = 0, n_pass = 0;
  logic [3:0] m_ctrl = '0;
  logic [63:0] m_a = '0, m_b = '0;
  logic [15:0] m_count = '0;
  alu_op_sequencer #(.DATA_W(64), .CNT_W(16)) dut (
    .CLK(CLK), .resetl(resetl), .op_valid(op_valid), .op_ready(op_ready), .Opcode(Opcode),
    .OperandA(OperandA), .OperandB(OperandB), .AluCtrl(AluCtrl), .BusA(BusA), .BusB(BusB),
    .BusW(BusW), .Zero(Zero), .res_valid(res_valid), .res_ready(res_ready), .Result(Result),
    .ResZero(ResZero), .Illegal(Illegal), .op_count(op_count)
  );
  always #5 CLK = ~CLK;
  always_comb begin
    BusW = AluCtrl == 4'b0000 ? (BusA & BusB) :
           AluCtrl == 4'b0001 ? (BusA | BusB) :
           AluCtrl == 4'b0010 ? (BusA + BusB) :
           AluCtrl == 4'b0110 ? (BusA - BusB) :
           AluCtrl == 4'b0111 ? BusB : 64'hDEAD_BEEF_0BAD_F00D;
    Zero = BusW == 64'd0;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic int kind(input logic [10:0] op);
    if (op == 11'b10001011000) return 0;
    if (op == 11'b11001011000) return 1;
    if (op == 11'b10001010000) return 2;
    if (op == 11'b10101010000) return 3;
    if (op == 11'b11111000010) return 4;
    if (op == 11'b11111000000) return 5;
    if (op[10:3] == 8'b10110100) return 6;
    return -1;
  endfunction
  function automatic logic [3:0] kind_ctrl(input int k);
    logic [3:0] tbl [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0010, 4'b0010, 4'b0111};
    return tbl[k];
  endfunction
  function automatic logic [63:0] kind_result(input int k, input logic [63:0] a, input logic [63:0] b);
    if (k == 1) return a - b;
    if (k == 2) return a & b;
    if (k == 3) return a | b;
    if (k == 6) return b;
    return a + b;
  endfunction
  task automatic run_op(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b, input int hold);
    int k;
    logic [63:0] r;
    k = kind(op);
    r = 64'd0;
    check("ready_idle", op_ready, 1);
    op_valid = 1'b1;
    Opcode = op;
    OperandA = a;
    OperandB = b;
    @(negedge CLK);
    op_valid = 1'b0;
    Opcode = 11'($urandom);
    OperandA = {$urandom, $urandom};
    OperandB = {$urandom, $urandom};
    if (k >= 0) begin
      m_ctrl = kind_ctrl(k);
      m_a = a;
      m_b = b;
      r = kind_result(k, a, b);
    end
    check("alu_ctrl", AluCtrl, m_ctrl);
    check("bus_a", BusA, m_a);
    check("bus_b", BusB, m_b);
    check("ready_busy", op_ready, 0);
    if (k >= 0) begin
      check("resv_exec", res_valid, 0);
      @(negedge CLK);
    end
    for (int i = 0; i <= hold; i++) begin
      check("res_valid", res_valid, 1);
      check("result", Result, r);
      check("res_zero", ResZero, 64'(k >= 0 && r == 64'd0));
      check("illegal", Illegal, 64'(k < 0));
      check("ready_resp", op_ready, 0);
      check("count_hold", op_count, m_count);
      if (i < hold) @(negedge CLK);
    end
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
    m_count++;
    check("resv_done", res_valid, 0);
    check("ready_done", op_ready, 1);
    check("count", op_count, m_count);
  endtask
  initial begin
    logic [10:0] op;
    logic [63:0] a, b;
    logic [10:0] legal [6] = '{11'b10001011000, 11'b11001011000, 11'b10001010000,
                               11'b10101010000, 11'b11111000010, 11'b11111000000};
    repeat (2) @(negedge CLK);
    check("rst_ready", op_ready, 0);
    check("rst_resv", res_valid, 0);
    check("rst_ctrl", AluCtrl, 0);
    check("rst_count", op_count, 0);
    resetl = 1'b1;
    @(negedge CLK);
    check("rst_result", Result, 0);
    check("rst_illegal", Illegal, 0);
    run_op(11'b10001011000, 64'd5, 64'd7, 0);
    run_op(11'b11001011000, 64'd9, 64'd9, 0);
    run_op(11'b10110100101, 64'hFF, 64'd0, 0);
    run_op(11'b10110100101, 64'hFF, 64'd3, 0);
    run_op(11'b00000000000, 64'd1, 64'd2, 0);
    run_op(11'b10101010000, 64'hF0, 64'h0F, 5);
    repeat (2) @(negedge CLK);
    check("idle_resv", res_valid, 0);
    check("idle_ready", op_ready, 1);
    op_valid = 1'b1;
    Opcode = 11'b10001011000;
    OperandA = 64'd100;
    OperandB = 64'd1;
    @(negedge CLK);
    op_valid = 1'b0;
    resetl = 1'b0;
    @(negedge CLK);
    m_ctrl = '0;
    m_a = '0;
    m_b = '0;
    m_count = '0;
    check("abort_ready", op_ready, 0);
    check("abort_resv", res_valid, 0);
    check("abort_ctrl", AluCtrl, 0);
    check("abort_bus_a", BusA, 0);
    check("abort_bus_b", BusB, 0);
    check("abort_result", Result, 0);
    check("abort_count", op_count, 0);
    resetl = 1'b1;
    @(negedge CLK);
    check("abort_noresp", res_valid, 0);
    run_op(11'b10001011000, 64'd20, 64'd22, 1);
    for (int n = 0; n < 60; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      op = sel < 6 ? legal[sel] : sel == 6 ? {8'b10110100, 3'($urandom)} : 11'($urandom);
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 5)) : {$urandom, $urandom});
      run_op(op, a, b, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) @(negedge CLK);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
